// File: rtl/cpu_trace_checker_pkg.sv
// Shared types and constants for the CPU trace record checker.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TIME,
    ST_PC,
    ST_COLON_SP,
    ST_GRF_FIRST,
    ST_GRF,
    ST_PRE_ARROW,
    ST_ADDR,
    ST_ARROW_EQ,
    ST_DATA_SP,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SP     = 8'h20;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  // True when v is word aligned and inside [lo, hi].
  function automatic logic aligned_in_window(input logic [31:0] v,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
    return (v >= lo) && (v <= hi) && (v[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cpu_trace_checker_if.sv
// Character input, frequency and parsed-record outputs of the trace checker.
interface cpu_trace_checker_if #(
  parameter int unsigned FREQ_W = 16
);
  logic [7:0]        char;
  logic [FREQ_W-1:0] freq;
  logic [1:0]        format_type;
  logic [3:0]        error_code;
  logic [FREQ_W-1:0] rec_time;
  logic [31:0]       rec_pc;
  logic [31:0]       rec_target;
  logic [31:0]       rec_data;

  modport master (
    output char, freq,
    input  format_type, error_code, rec_time, rec_pc, rec_target, rec_data
  );

  modport slave (
    input  char, freq,
    output format_type, error_code, rec_time, rec_pc, rec_target, rec_data
  );
endinterface

// File: rtl/cpu_trace_checker_char_class.sv
// ASCII character classifier: decimal digit, hex digit and nibble value.
// CPU_TRACE_CHECKER_UPPERHEX_EN additionally accepts 'A'-'F' as hex digits.
module trace_char_class (
  input  logic [7:0] ch,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // Decode the character into its digit class and value.
  always_comb begin
    is_dec = 1'b0;
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_dec = 1'b1;
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h30);
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h57);
    end
`ifdef CPU_TRACE_CHECKER_UPPERHEX_EN
    else if (ch >= 8'h41 && ch <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h37);
    end
`else
`endif
  end

endmodule

// File: rtl/cpu_trace_checker.sv
// Byte-serial parser/validator for register- and memory-write trace records.
// Optional macro CPU_TRACE_CHECKER_UPPERHEX_EN enables uppercase hex digits.
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter int unsigned FREQ_W      = 16,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4FFF,
  parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2FFF,
  parameter int unsigned GRF_MAX     = 31
) (
  input logic               clk,
  input logic               reset,
  cpu_trace_checker_if.slave bus
);

  localparam int unsigned HEX_DIGITS = 8;
  localparam int unsigned CNT_MAX_A  = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
  localparam int unsigned CNT_MAX    = (CNT_MAX_A > HEX_DIGITS) ? CNT_MAX_A : HEX_DIGITS;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TIME_LIM = CNT_W'(TIME_DIGITS);
  localparam logic [CNT_W-1:0] GRF_LIM  = CNT_W'(GRF_DIGITS);
  localparam logic [CNT_W-1:0] HEX_LIM  = CNT_W'(HEX_DIGITS);

  state_t            state, state_next;
  logic [FREQ_W-1:0] time_acc, time_next;
  logic [31:0]       pc_acc, pc_next;
  logic [15:0]       grf_acc, grf_next;
  logic [31:0]       addr_acc, addr_next;
  logic [31:0]       data_acc, data_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              is_mem, is_mem_next;

  logic [1:0]        fmt_next;
  logic [3:0]        err_next;
  logic [FREQ_W-1:0] rtime_next;
  logic [31:0]       rpc_next, rtgt_next, rdata_next;

  logic              is_dec, is_hex;
  logic [3:0]        nibble;
  logic [FREQ_W-1:0] freq_mask;

  trace_char_class u_class (
    .ch     (bus.char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  // Low bits that must be zero for time to be a multiple of freq/2.
  assign freq_mask = (bus.freq >> 1) - FREQ_W'(1);

  // Next-state, accumulator and record-output logic.
  always_comb begin
    state_next  = state;
    time_next   = time_acc;
    pc_next     = pc_acc;
    grf_next    = grf_acc;
    addr_next   = addr_acc;
    data_next   = data_acc;
    cnt_next    = cnt;
    is_mem_next = is_mem;
    fmt_next    = FMT_NONE;
    err_next    = 4'h0;
    rtime_next  = bus.rec_time;
    rpc_next    = bus.rec_pc;
    rtgt_next   = bus.rec_target;
    rdata_next  = bus.rec_data;

    if (bus.char == CH_CARET) begin
      state_next  = ST_TIME;
      time_next   = '0;
      pc_next     = '0;
      grf_next    = '0;
      addr_next   = '0;
      data_next   = '0;
      cnt_next    = '0;
      is_mem_next = 1'b0;
    end else begin
      state_next = ST_IDLE;
      case (state)
        ST_TIME: begin
          if (is_dec && cnt != TIME_LIM) begin
            state_next = ST_TIME;
            time_next  = time_acc * FREQ_W'(10) + FREQ_W'(nibble);
            cnt_next   = cnt + CNT_W'(1);
          end else if (bus.char == CH_AT && cnt != '0) begin
            state_next = ST_PC;
            cnt_next   = '0;
          end
        end
        ST_PC: begin
          if (is_hex && cnt != HEX_LIM) begin
            state_next = ST_PC;
            pc_next    = {pc_acc[27:0], nibble};
            cnt_next   = cnt + CNT_W'(1);
          end else if (bus.char == CH_COLON && cnt == HEX_LIM) begin
            state_next = ST_COLON_SP;
            cnt_next   = '0;
          end
        end
        ST_COLON_SP: begin
          if (bus.char == CH_SP) begin
            state_next = ST_COLON_SP;
          end else if (bus.char == CH_DOLLAR) begin
            state_next  = ST_GRF_FIRST;
            is_mem_next = 1'b0;
          end else if (bus.char == CH_STAR) begin
            state_next  = ST_ADDR;
            is_mem_next = 1'b1;
            cnt_next    = '0;
          end
        end
        ST_GRF_FIRST: begin
          if (is_dec) begin
            state_next = ST_GRF;
            grf_next   = 16'(nibble);
            cnt_next   = CNT_W'(1);
          end
        end
        ST_GRF: begin
          if (is_dec && cnt != GRF_LIM) begin
            state_next = ST_GRF;
            grf_next   = grf_acc * 16'd10 + 16'(nibble);
            cnt_next   = cnt + CNT_W'(1);
          end else if (bus.char == CH_SP) begin
            state_next = ST_PRE_ARROW;
          end else if (bus.char == CH_LT) begin
            state_next = ST_ARROW_EQ;
          end
        end
        ST_ADDR: begin
          if (is_hex && cnt != HEX_LIM) begin
            state_next = ST_ADDR;
            addr_next  = {addr_acc[27:0], nibble};
            cnt_next   = cnt + CNT_W'(1);
          end else if (bus.char == CH_SP && cnt == HEX_LIM) begin
            state_next = ST_PRE_ARROW;
          end else if (bus.char == CH_LT && cnt == HEX_LIM) begin
            state_next = ST_ARROW_EQ;
          end
        end
        ST_PRE_ARROW: begin
          if (bus.char == CH_SP) state_next = ST_PRE_ARROW;
          else if (bus.char == CH_LT) state_next = ST_ARROW_EQ;
        end
        ST_ARROW_EQ: begin
          if (bus.char == CH_EQ) state_next = ST_DATA_SP;
        end
        ST_DATA_SP: begin
          if (bus.char == CH_SP) begin
            state_next = ST_DATA_SP;
          end else if (is_hex) begin
            state_next = ST_DATA;
            data_next  = 32'(nibble);
            cnt_next   = CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (is_hex && cnt != HEX_LIM) begin
            state_next = ST_DATA;
            data_next  = {data_acc[27:0], nibble};
            cnt_next   = cnt + CNT_W'(1);
          end else if (bus.char == CH_HASH && cnt == HEX_LIM) begin
            state_next  = ST_DONE;
            err_next[0] = (time_acc & freq_mask) != '0;
            err_next[1] = !aligned_in_window(pc_acc, PC_LO, PC_HI);
            rtime_next  = time_acc;
            rpc_next    = pc_acc;
            rdata_next  = data_acc;
            if (is_mem) begin
              fmt_next    = FMT_MEM;
              err_next[2] = !aligned_in_window(addr_acc, ADDR_LO, ADDR_HI);
              rtgt_next   = addr_acc;
            end else begin
              fmt_next    = FMT_REG;
              err_next[3] = 32'(grf_acc) > GRF_MAX;
              rtgt_next   = 32'(grf_acc);
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State, accumulators and registered record outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      time_acc        <= '0;
      pc_acc          <= '0;
      grf_acc         <= '0;
      addr_acc        <= '0;
      data_acc        <= '0;
      cnt             <= '0;
      is_mem          <= 1'b0;
      bus.format_type <= FMT_NONE;
      bus.error_code  <= 4'h0;
      bus.rec_time    <= '0;
      bus.rec_pc      <= '0;
      bus.rec_target  <= '0;
      bus.rec_data    <= '0;
    end else begin
      state           <= state_next;
      time_acc        <= time_next;
      pc_acc          <= pc_next;
      grf_acc         <= grf_next;
      addr_acc        <= addr_next;
      data_acc        <= data_next;
      cnt             <= cnt_next;
      is_mem          <= is_mem_next;
      bus.format_type <= fmt_next;
      bus.error_code  <= err_next;
      bus.rec_time    <= rtime_next;
      bus.rec_pc      <= rpc_next;
      bus.rec_target  <= rtgt_next;
      bus.rec_data    <= rdata_next;
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed bench for cpu_trace_checker: feeds trace strings, checks parsed records.
module tb_cpu_trace_checker;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  snap_ft;
  logic [3:0]  snap_err;
  logic [31:0] snap_time, snap_pc, snap_tgt, snap_data;

  cpu_trace_checker_if #(.FREQ_W(16)) bus ();

  cpu_trace_checker #(.FREQ_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture all outputs at the current (falling-edge) sample point.
  task automatic take_snap();
    snap_ft   = bus.format_type;
    snap_err  = bus.error_code;
    snap_time = 32'(bus.rec_time);
    snap_pc   = bus.rec_pc;
    snap_tgt  = bus.rec_target;
    snap_data = bus.rec_data;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [1:0] ft, input logic [3:0] err,
                         input logic [31:0] tm, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [31:0] data);
    chk({tag, ".fmt"},    32'(snap_ft),  32'(ft));
    chk({tag, ".err"},    32'(snap_err), 32'(err));
    chk({tag, ".time"},   snap_time,     tm);
    chk({tag, ".pc"},     snap_pc,       pc);
    chk({tag, ".target"}, snap_tgt,      tgt);
    chk({tag, ".data"},   snap_data,     data);
  endtask

  // Drive one character per cycle; outputs are snapshotted before the first one.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      if (i == 0) take_snap();
      bus.char = s[i];
    end
  endtask

  task automatic idle();
    @(negedge clk);
    take_snap();
    bus.char = 8'h00;
  endtask

  initial begin
    reset    = 1'b1;
    bus.char = 8'h00;
    bus.freq = 16'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    take_snap();
    chk_rec("reset", 2'b00, 4'h0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Clean register record.
    bus.freq = 16'd4;
    send_str("^10@00003004: $3 <= 0000abcd#");
    idle();
    chk_rec("r1", 2'b01, 4'b0000, 32'd10, 32'h3004, 32'd3, 32'h0000abcd);
    idle();
    chk("r1.fmt_clear", 32'(snap_ft), 32'd0);
    chk("r1.err_clear", 32'(snap_err), 32'd0);
    chk("r1.data_hold", snap_data, 32'h0000abcd);

    // Memory record with time, pc and addr errors.
    send_str("^7@00002ffe:   *00003000 <= 12345678#");
    idle();
    chk_rec("r2", 2'b10, 4'b0111, 32'd7, 32'h2ffe, 32'h3000, 32'h12345678);

    // grf above limit, then back-to-back into an over-long time field.
    bus.freq = 16'd2;
    send_str("^5@00003000: $32<=00000000#");
    send_str("^12345@00003000: $1 <= 00000001#");
    chk_rec("r3", 2'b01, 4'b1000, 32'd5, 32'h3000, 32'd32, 32'd0);
    bus.freq = 16'd8;
    send_str("^20@00004ffc: *00002ffc <= deadbeef#");
    chk("r4.fmt_none", 32'(snap_ft), 32'd0);
    chk("r4.time_hold", snap_time, 32'd5);
    idle();
    chk_rec("r5", 2'b10, 4'b0000, 32'd20, 32'h4ffc, 32'h2ffc, 32'hdeadbeef);

    // Restart in the middle of the pc field.
    bus.freq = 16'd2;
    send_str("^1@000030");
    send_str("^2@00003000: $1 <= 00000001#");
    idle();
    chk_rec("r6", 2'b01, 4'b0000, 32'd2, 32'h3000, 32'd1, 32'd1);

    // Maximum time and grf digit counts.
    bus.freq = 16'd4;
    send_str("^9996@00003000: $1234 <= 00000010#");
    idle();
    chk_rec("r7", 2'b01, 4'b1000, 32'd9996, 32'h3000, 32'd1234, 32'h10);

    // Misaligned pc inside the window.
    bus.freq = 16'd16;
    send_str("^0@00003002: *00000000 <= ffffffff#");
    idle();
    chk_rec("r8", 2'b10, 4'b0010, 32'd0, 32'h3002, 32'd0, 32'hffffffff);

    // Nine pc digits and five grf digits are both rejected.
    send_str("^3@000030000: $1 <= 00000001#");
    idle();
    chk("r9.fmt_none", 32'(snap_ft), 32'd0);
    chk("r9.data_hold", snap_data, 32'hffffffff);
    send_str("^4@00003000: $12345 <= 00000001#");
    idle();
    chk("r10.fmt_none", 32'(snap_ft), 32'd0);
    chk("r10.pc_hold", snap_pc, 32'h3002);

    // Reset in the middle of the data field.
    bus.freq = 16'd4;
    send_str("^4@00003008: $7 <= 0000");
    @(negedge clk);
    reset    = 1'b1;
    bus.char = 8'h00;
    @(negedge clk);
    take_snap();
    reset = 1'b0;
    chk_rec("r11", 2'b00, 4'h0, 32'd0, 32'd0, 32'd0, 32'd0);
    send_str("^8@00003008: $7 <= 0000abcd#");
    idle();
    chk_rec("r12", 2'b01, 4'b0000, 32'd8, 32'h3008, 32'd7, 32'h0000abcd);

    // grf at its legal maximum.
    send_str("^6@00004ffc: $31 <= 00000000#");
    idle();
    chk_rec("r13", 2'b01, 4'b0000, 32'd6, 32'h4ffc, 32'd31, 32'd0);

    // Uppercase hex in the data field.
    send_str("^12@00003000: $2 <= 0000ABCD#");
    idle();
`ifdef CPU_TRACE_CHECKER_UPPERHEX_EN
    chk_rec("r14", 2'b01, 4'b0000, 32'd12, 32'h3000, 32'd2, 32'h0000abcd);
`else
    chk("r14.fmt_none", 32'(snap_ft), 32'd0);
    chk("r14.time_hold", snap_time, 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Byte-serial parser and validator for CPU trace records arriving one ASCII character per clock.
- Recognises register-write records `^<time>@<pc>: $<grf> <= <data>#` and memory-write records `^<time>@<pc>: *<addr> <= <data>#`.
- Reports the record type, a 4-bit error code and the captured fields.
- Parametrised successor to the fixed-format checker: digit limits, legal PC/address windows and frequency width are configurable, and field capture is new.

Parameters:
- TIME_DIGITS, 4: maximum decimal digits in time; minimum is 1.
- GRF_DIGITS, 4: maximum decimal digits in grf; minimum is 1.
- FREQ_W, 16: width of freq input and of the time accumulator.
- PC_LO, 32'h0000_3000: lowest legal PC, inclusive.
- PC_HI, 32'h0000_4FFF: highest legal PC, inclusive.
- ADDR_LO, 32'h0000_0000: lowest legal memory address, inclusive.
- ADDR_HI, 32'h0000_2FFF: highest legal memory address, inclusive.
- GRF_MAX, 31: highest legal register number.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- char  in  8  ASCII character, one sampled per rising edge.
- freq  in  FREQ_W  CPU frequency; power of two, at least 2; sampled when '#' is accepted.
- format_type  out  2  00 none, 01 register record, 10 memory record.
- error_code  out  4  bit0 time, bit1 pc, bit2 addr, bit3 grf.
- rec_time  out  FREQ_W  captured time.
- rec_pc  out  32  captured pc.
- rec_target  out  32  grf number (zero-extended) or memory address.
- rec_data  out  32  captured data.

Behaviour:
- Reset (synchronous, active-high; clock clk): state IDLE; all outputs and internal accumulators and counters go to 0. Reset mid-record discards the record.
- States: IDLE, TIME, PC, COLON_SP, GRF_FIRST, GRF, PRE_ARROW, ADDR, ARROW_EQ, DATA_SP, DATA, DONE.
- Any state, char '^': go to TIME and clear accumulators and counters. This overrides every other transition. A '^' arriving in DONE still lets DONE's outputs stand for that cycle.
- Any other unexpected char in any state: go to IDLE and produce no output.
- IDLE: stay in IDLE until '^'.
- TIME: decimal digit → time = time*10 + digit, cnt++.
  - '@' with 1 ≤ cnt ≤ TIME_DIGITS → PC.
  - A digit that would make cnt exceed TIME_DIGITS → IDLE.
- PC: hex digit → pc = (pc<<4) | nibble.
  - ':' after exactly 8 digits → COLON_SP.
  - A ninth digit → IDLE.
- COLON_SP: ' ' stays; '$' → GRF_FIRST; '*' → ADDR.
- GRF_FIRST: first grf digit required, then → GRF.
- GRF: further digits up to GRF_DIGITS total. ' ' → PRE_ARROW; '<' → ARROW_EQ.
- ADDR: exactly 8 hex digits. ' ' → PRE_ARROW; '<' → ARROW_EQ.
- PRE_ARROW: ' ' stays; '<' → ARROW_EQ.
- ARROW_EQ: '=' → DATA_SP.
- DATA_SP: ' ' stays; hex digit → DATA and the digit is captured.
- DATA: exactly 8 hex digits total, then '#' → DONE.
- Accumulator arithmetic: time and grf accumulate modulo 2^FREQ_W and 2^16 respectively. Overflow is impossible within the digit limits when the parameters are sane.
- Outputs on '#':
  - format_type, error_code and rec_* are registered on the edge that accepts '#'.
  - They are visible for exactly the following cycle (DONE); latency from '#' is 1 cycle.
  - format_type returns to 00 on the next edge. rec_* hold until the next accepted record.
- Errors (all zero if format_type is 00):
  - bit0 = (time & (freq/2 - 1)) != 0, i.e. time is not a multiple of freq/2.
  - bit1 = pc < PC_LO, or pc > PC_HI, or pc[1:0] != 0.
  - bit2 (memory records only) = addr outside [ADDR_LO, ADDR_HI], or addr[1:0] != 0.
  - bit3 (register records only) = grf > GRF_MAX.
- Hex digits are '0'-'9' and 'a'-'f' only.
- Back-to-back records with no gap are supported.

Optional Feature:
- Macro: CPU_TRACE_CHECKER_UPPERHEX_EN.
- Defined: 'A'-'F' are also accepted as hex digits, nibble values 10-15, in pc, addr and data.
- Undefined: uppercase letters are illegal and send the parser to IDLE.

Decomposition:
- Package cpu_trace_pkg holds:
  - the state enum;
  - ASCII constants for '^', '@', ':', '$', '*', '<', '=', '#' and ' ';
  - the format_type encodings FMT_NONE, FMT_REG and FMT_MEM.
- One sub-module, trace_char_class: combinational classifier from char to is_dec, is_hex and nibble[3:0]. It contains the UPPERHEX option.

Test Plan:
- "^10@00003004: $3 <= 0000abcd#" with freq=4 → format_type=01, error=0000, rec_pc=0x3004, rec_target=3, rec_data=0xabcd, one cycle after '#'.
- "^7@00002ffe:   *00003000 <= 12345678#" with freq=4 → format_type=10, error=0111 (time 7 not a multiple of 2, pc below range, addr out of range).
- "^5@00003000: $32<=00000000#" with freq=2 → format_type=01, error=1000.
- "^12345@00003000: ..." (5 time digits) → no output; the next valid record parses normally.
- "^1@000030" followed by "^2@00003000: $1 <= 00000001#" → the restart is honoured, format_type=01, rec_time=2.
- reset asserted mid-DATA, then a full valid record → no output for the aborted record, normal output for the second; with UPPERHEX_EN, "…<= 0000ABCD#" → rec_data=0xABCD.
